// File: rtl/atm_pkg.sv
// Shared types and default parameters for the ATM cash-intake datapath.
package atm_pkg;

  localparam int unsigned N_DENOM_DEFAULT = 6;
  localparam int unsigned AMT_W_DEFAULT   = 8;
  localparam int unsigned TOTAL_W_DEFAULT = 12;

  // Slice i holds the value of switch[i]; slice 0 is the least significant byte.
  localparam logic [N_DENOM_DEFAULT*AMT_W_DEFAULT-1:0] DENOM_VALUES_DEFAULT =
    {8'd100, 8'd50, 8'd20, 8'd10, 8'd5, 8'd1};

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/switch_debouncer.sv
// Synchronises a raw switch bank and accepts a value only after DEBOUNCE identical samples.
module switch_debouncer #(
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned DEBOUNCE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable_sw
);

  localparam int unsigned CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] stable_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next_c;

  // The counter saturates once the candidate has been accepted.
  always_comb begin
    cnt_next_c = cnt;
    if (sync2 != cand) begin
      cnt_next_c = '0;
    end else if (cnt != CNT_LAST) begin
      cnt_next_c = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      cand     <= '0;
      cnt      <= '0;
      stable_q <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      cand  <= sync2;
      cnt   <= cnt_next_c;
      // The sample arriving now is the DEBOUNCE-th identical one.
      if (cnt_next_c == CNT_LAST) begin
        stable_q <= sync2;
      end
    end
  end

  assign stable_sw = stable_q;

endmodule

// File: rtl/denomination_accumulator.sv
// Debounced denomination decode, saturating deposit accumulator and valid/ready commit.
module denomination_accumulator
  import atm_pkg::*;
#(
  parameter int unsigned N_DENOM  = N_DENOM_DEFAULT,
  parameter int unsigned AMT_W    = AMT_W_DEFAULT,
  parameter int unsigned TOTAL_W  = TOTAL_W_DEFAULT,
  parameter logic [N_DENOM*AMT_W-1:0] DENOM_VALUES = DENOM_VALUES_DEFAULT,
  parameter logic [TOTAL_W-1:0] MAX_TOTAL = TOTAL_W'(4000),
  parameter int unsigned DEBOUNCE = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_DENOM-1:0] switch,
  input  logic               add_i,
  input  logic               clear_i,
  input  logic               commit_i,
  input  logic               out_ready_i,
  output logic [AMT_W-1:0]   amount_o,
  output logic               invalid_led_o,
  output logic [TOTAL_W-1:0] total_o,
  output logic               out_valid_o,
  output logic               sat_o
);

  localparam int unsigned POP_W = $clog2(N_DENOM + 1);

  logic [N_DENOM-1:0] stable_sw;
  logic [POP_W-1:0]   ones_c;
  logic [AMT_W-1:0]   sel_amount_c;
  logic [AMT_W-1:0]   amount_c;
  logic [TOTAL_W:0]   sum_c;

  state_t             state;
  logic [TOTAL_W-1:0] total;
  logic               sat;
  logic               out_valid;

  switch_debouncer #(
    .WIDTH    (N_DENOM),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw       (switch),
    .stable_sw (stable_sw)
  );

  // Population count and table lookup; the lookup is only used when exactly one bit is set.
  always_comb begin
    ones_c       = '0;
    sel_amount_c = '0;
    for (int i = 0; i < int'(N_DENOM); i++) begin
      ones_c = ones_c + POP_W'(stable_sw[i]);
      if (stable_sw[i]) begin
        sel_amount_c = DENOM_VALUES[i*AMT_W +: AMT_W];
      end
    end
    amount_c = (ones_c == POP_W'(1)) ? sel_amount_c : '0;
  end

  assign amount_o      = amount_c;
  assign invalid_led_o = (ones_c > POP_W'(1));

  // One bit of headroom so an over-limit sum is seen rather than wrapped.
  assign sum_c = {1'b0, total} + (TOTAL_W + 1)'(amount_c);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACCUM;
      total     <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (clear_i) begin
            total <= '0;
            sat   <= 1'b0;
          end else if (commit_i) begin
            if (total != '0) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end else if (add_i && (amount_c != '0)) begin
            if (sum_c <= {1'b0, MAX_TOTAL}) begin
              total <= sum_c[TOTAL_W-1:0];
            end else begin
              sat <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            total     <= '0;
            sat       <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign total_o     = total;
  assign sat_o       = sat;
  assign out_valid_o = out_valid;

endmodule

// File: tb/tb_denomination_accumulator.sv
// Directed bench for denomination_accumulator with hand-computed expectations.
module tb_denomination_accumulator;

  logic        clk;
  logic        rst_n;
  logic [5:0]  switch;
  logic        add_i;
  logic        clear_i;
  logic        commit_i;
  logic        out_ready_i;
  logic [7:0]  amount_o;
  logic        invalid_led_o;
  logic [11:0] total_o;
  logic        out_valid_o;
  logic        sat_o;

  int unsigned n_checks;
  int unsigned n_pass;

  denomination_accumulator dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .switch        (switch),
    .add_i         (add_i),
    .clear_i       (clear_i),
    .commit_i      (commit_i),
    .out_ready_i   (out_ready_i),
    .amount_o      (amount_o),
    .invalid_led_o (invalid_led_o),
    .total_o       (total_o),
    .out_valid_o   (out_valid_o),
    .sat_o         (sat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".amount"}, 32'(amount_o), 32'd0);
    check({tag, ".led"},    32'(invalid_led_o), 32'd0);
    check({tag, ".total"},  32'(total_o), 32'd0);
    check({tag, ".valid"},  32'(out_valid_o), 32'd0);
    check({tag, ".sat"},    32'(sat_o), 32'd0);
  endtask

  task automatic pulse_add(input int n);
    add_i = 1'b1;
    tick(n);
    add_i = 1'b0;
  endtask

  task automatic settle_switch(input logic [5:0] v);
    switch = v;
    tick(18);
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    switch      = '0;
    add_i       = 1'b0;
    clear_i     = 1'b0;
    commit_i    = 1'b0;
    out_ready_i = 1'b0;
    tick(2);
    check_all_zero("reset");
    rst_n = 1'b1;

    // $10 switch appears exactly 18 edges after it is driven
    switch = 6'b000100;
    tick(17);
    check("deb_early.amount", 32'(amount_o), 32'd0);
    tick(1);
    check("deb_on_time.amount", 32'(amount_o), 32'd10);
    check("deb_on_time.led", 32'(invalid_led_o), 32'd0);
    pulse_add(1);
    check("add1.total", 32'(total_o), 32'd10);
    pulse_add(2);
    check("add3.total", 32'(total_o), 32'd30);

    // Bouncing between $20 and $10 every 5 cycles must never disturb the stable value
    for (int p = 0; p < 8; p++) begin
      switch = (p % 2 == 0) ? 6'b001000 : 6'b000100;
      for (int c = 0; c < 5; c++) begin
        tick(1);
        check("bounce.amount", 32'(amount_o), 32'd10);
      end
    end
    switch = 6'b001000;
    tick(17);
    check("post_bounce_early.amount", 32'(amount_o), 32'd10);
    tick(1);
    check("post_bounce.amount", 32'(amount_o), 32'd20);

    // Two switches: invalid, and add has no effect
    settle_switch(6'b100010);
    check("invalid.led", 32'(invalid_led_o), 32'd1);
    check("invalid.amount", 32'(amount_o), 32'd0);
    pulse_add(1);
    check("invalid_add.total", 32'(total_o), 32'd30);

    // Saturation at 4000 with $100 notes
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    check("clear.total", 32'(total_o), 32'd0);
    settle_switch(6'b100000);
    check("hundred.amount", 32'(amount_o), 32'd100);
    pulse_add(39);
    check("add39.total", 32'(total_o), 32'd3900);
    pulse_add(1);
    check("add40.total", 32'(total_o), 32'd4000);
    check("add40.sat", 32'(sat_o), 32'd0);
    pulse_add(1);
    check("add41.total", 32'(total_o), 32'd4000);
    check("add41.sat", 32'(sat_o), 32'd1);
    add_i   = 1'b1;
    clear_i = 1'b1;
    tick(1);
    add_i   = 1'b0;
    clear_i = 1'b0;
    check("clear_sat.total", 32'(total_o), 32'd0);
    check("clear_sat.sat", 32'(sat_o), 32'd0);

    // Build 55, then commit with a simultaneous add that must be dropped
    settle_switch(6'b010000);
    pulse_add(1);
    settle_switch(6'b000010);
    pulse_add(1);
    check("build55.total", 32'(total_o), 32'd55);
    commit_i = 1'b1;
    add_i    = 1'b1;
    tick(1);
    commit_i = 1'b0;
    check("commit.valid", 32'(out_valid_o), 32'd1);
    check("commit.total", 32'(total_o), 32'd55);
    clear_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(1);
      check("hold.valid", 32'(out_valid_o), 32'd1);
      check("hold.total", 32'(total_o), 32'd55);
    end
    add_i       = 1'b0;
    clear_i     = 1'b0;
    out_ready_i = 1'b1;
    tick(1);
    out_ready_i = 1'b0;
    check("release.valid", 32'(out_valid_o), 32'd0);
    check("release.total", 32'(total_o), 32'd0);

    // Reset while in HOLD
    pulse_add(1);
    check("rehold.total", 32'(total_o), 32'd5);
    commit_i = 1'b1;
    tick(1);
    commit_i = 1'b0;
    check("rehold.valid", 32'(out_valid_o), 32'd1);
    rst_n = 1'b0;
    tick(1);
    check_all_zero("rst_hold");
    rst_n    = 1'b1;
    commit_i = 1'b1;
    tick(1);
    commit_i = 1'b0;
    check("rst_hold_commit0.valid", 32'(out_valid_o), 32'd0);

    // Reset mid-debounce restarts the full synchroniser + debounce latency
    switch = 6'b000100;
    tick(8);
    rst_n = 1'b0;
    tick(1);
    check_all_zero("rst_deb");
    rst_n = 1'b1;
    tick(17);
    check("rst_deb_early.amount", 32'(amount_o), 32'd0);
    tick(1);
    check("rst_deb_late.amount", 32'(amount_o), 32'd10);
    commit_i = 1'b1;
    tick(1);
    commit_i = 1'b0;
    check("rst_deb_commit0.valid", 32'(out_valid_o), 32'd0);
    check("rst_deb_commit0.total", 32'(total_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/denomination_accumulator.md
# denomination_accumulator

Parametrised cash-intake block for the ATM datapath. Debounces a one-hot denomination switch bank, decodes the selected position to a value from a parameter table and flags illegal multi-switch selections. It accumulates a deposit total on operator add strobes and hands the total to the downstream ledger over a valid/ready handshake. It supersedes the pure combinational switch decoder by adding debounce, accumulation, saturation and commit.

## Interface
- N_DENOM, 6: number of denomination switches, with one value per switch.
- AMT_W, 8: width of one denomination value.
- TOTAL_W, 12: width of the running total.
- DENOM_VALUES, {8'd100,8'd50,8'd20,8'd10,8'd5,8'd1}: packed N_DENOM*AMT_W table. Slice i is the value of switch[i].
- MAX_TOTAL, 12'd4000: largest legal total, which must fit in TOTAL_W.
- DEBOUNCE, 16: number of consecutive identical samples required before the switch value is accepted. Legal range is ≥1.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- switch  in  N_DENOM  raw switch bank, asynchronous to clk (the sub-module double-flops it).
- add_i  in  1  one-cycle strobe that adds the current denomination to the total.
- clear_i  in  1  one-cycle strobe that zeroes the total and clears sat_o.
- commit_i  in  1  one-cycle strobe that offers the total downstream.
- out_ready_i  in  1  downstream accepts the total.
- amount_o  out  AMT_W  decoded value of the stable switch; 0 if the stable switch is zero or invalid.
- invalid_led_o  out  1  high when the stable switch has more than one bit set.
- total_o  out  TOTAL_W  running total.
- out_valid_o  out  1  total_o is being offered downstream.
- sat_o  out  1  sticky flag: an add was rejected because it would exceed MAX_TOTAL.

## Operation
- Debounce:
  - A candidate register and a counter track the synchronised switch value.
  - When the value changes, the counter reloads to 0.
  - When the counter reaches DEBOUNCE-1 with the value unchanged, the candidate is copied to stable_sw.
- Decode from stable_sw:
  - Zero: amount 0, LED 0.
  - Exactly one bit i set: amount = DENOM_VALUES[i], LED 0.
  - Two or more bits set: amount 0, LED 1.
- FSM has two states:
  - ACCUM (reset state).
  - HOLD: out_valid_o = 1 and total_o is frozen.
- ACCUM: strobes are evaluated in priority order clear_i > commit_i > add_i. Only the highest-priority strobe present acts; the others that cycle are dropped.
  - clear_i: total ← 0, sat ← 0.
  - commit_i: if total ≠ 0, go to HOLD; if total = 0, ignore.
  - add_i, when amount_o ≠ 0:
    - If total + amount_o ≤ MAX_TOTAL: total ← total + amount_o. The sum is computed at TOTAL_W+1 bits, so there is no wrap.
    - Otherwise: total is unchanged and sat ← 1.
  - add_i when amount_o = 0 (no switch or invalid): no effect.
- HOLD:
  - add_i, clear_i and commit_i are all ignored.
  - When out_valid_o && out_ready_i: total ← 0, sat ← 0, go to ACCUM.
  - out_valid_o stays high until accepted; there is no timeout.
- Reset (rst_n = 0 at an edge), including mid-debounce or in HOLD:
  - FSM goes to ACCUM.
  - total, sat, stable_sw, candidate and counter all clear.
  - All outputs read 0 on the following cycle.

## Timing
- Switch to stable_sw: 2 synchroniser cycles + DEBOUNCE cycles.
- amount_o and invalid_led_o are combinational from stable_sw, so they update in the same cycle stable_sw updates.
- add_i at edge N: total_o updates after edge N. sat_o also updates after edge N.
- commit_i at edge N: out_valid_o = 1 after edge N.
- Handshake completes at the first edge where out_valid_o && out_ready_i. On the next cycle out_valid_o = 0 and total_o = 0.
- Minimum commit-to-release is 1 cycle (out_ready_i held high).
- Back-to-back add_i on consecutive cycles is legal; each adds.
- Reset values: amount_o 0, invalid_led_o 0, total_o 0, out_valid_o 0, sat_o 0.

## Structure
- Package atm_pkg:
  - Default denomination table constant.
  - Default AMT_W and TOTAL_W localparams.
  - FSM state enum: ACCUM and HOLD, 1 bit.
- Sub-module switch_debouncer:
  - Parametrised by width and DEBOUNCE.
  - Contains the 2-flop synchroniser, candidate register, counter and stable output.
- The top module holds the decode loop, the one-hot/popcount check, the accumulator, sat and the FSM.

## Test plan
- Reset, then switch = 6'b000100 held 2+16 cycles → amount_o = 10, invalid_led_o = 0. Then add_i ×3 → total_o = 30.
- Switch toggles every 5 cycles for 40 cycles (bounce) → stable_sw and amount_o never change. After the toggling stops, the new value appears exactly 2+16 cycles later.
- switch = 6'b100010 stable → invalid_led_o = 1, amount_o = 0. A subsequent add_i leaves total_o unchanged.
- With MAX_TOTAL = 4000: 40 adds of $100 → total_o = 4000. A 41st add → total_o stays 4000, sat_o = 1. Then clear_i → total_o = 0, sat_o = 0.
- total_o = 55, commit_i together with add_i → out_valid_o = 1 and total_o = 55 (add dropped). With out_ready_i low for 4 cycles, total_o holds at 55. Raise out_ready_i → next cycle out_valid_o = 0 and total_o = 0.
- Assert rst_n = 0 in HOLD, and separately mid-debounce → after one edge all outputs are 0, the FSM is in ACCUM, and commit_i with total 0 is ignored.
